// File: rtl/imm_extend_stage_if.sv
// imm_extend_stage_if: upstream and downstream valid/ready buses of the immediate stage.
interface imm_extend_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc4;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [31:0] out_target;
    logic [1:0]  out_ext_mode;
    logic [31:0] out_instr;
    modport master (output in_valid, in_instr, in_pc4, out_ready,
                    input in_ready, out_valid, out_imm, out_target, out_ext_mode, out_instr);
    modport slave (input in_valid, in_instr, in_pc4, out_ready,
                   output in_ready, out_valid, out_imm, out_target, out_ext_mode, out_instr);
endinterface

// File: rtl/imm_extend_stage.sv
// imm_extend_stage: registered immediate extension and branch target behind valid/ready handshakes.
// Define IMM_SKID_BUFFER_EN to add a skid entry so in_ready no longer depends on out_ready.
module imm_extend_stage #(
    parameter int BRANCH_SHIFT = 2,
    parameter bit ZEXT_LOGIC = 1'b1
) (
    input logic Clk,
    input logic Rst_n,
    input logic flush,
    imm_extend_stage_if.slave io
);
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [31:0] target;
        logic [1:0]  mode;
    } entry_t;
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t state, state_nxt;
    entry_t in_e, out_q;
    logic accept, load_out, zext, lui;
    logic [5:0] opc;
    logic [15:0] imm16;
    logic [31:0] sext;
`ifdef IMM_SKID_BUFFER_EN
    entry_t skid_q;
    logic load_skid, pop_skid;
    assign io.in_ready = state != FULL;
    always_ff @(posedge Clk or negedge Rst_n)
        if (!Rst_n) skid_q <= '0;
        else if (load_skid) skid_q <= in_e;
`else
    assign io.in_ready = state == EMPTY || io.out_ready;
`endif
    assign accept = io.in_valid && io.in_ready;
    always_comb begin
        opc = io.in_instr[31:26];
        imm16 = io.in_instr[15:0];
        zext = ZEXT_LOGIC && (opc == 6'h0C || opc == 6'h0D || opc == 6'h0E);
        lui = opc == 6'h0F;
        sext = {{16{imm16[15]}}, imm16};
        in_e.instr = io.in_instr;
        in_e.imm = lui ? {imm16, 16'h0} : zext ? {16'h0, imm16} : sext;
        in_e.mode = lui ? 2'b10 : zext ? 2'b01 : 2'b00;
        in_e.target = io.in_pc4 + (sext << BRANCH_SHIFT);
    end
    // Flush wins over everything: no load happens on a flush edge.
    always_comb begin
        state_nxt = state;
        load_out = 1'b0;
`ifdef IMM_SKID_BUFFER_EN
        load_skid = 1'b0;
        pop_skid = 1'b0;
`endif
        if (flush) state_nxt = EMPTY;
        else case (state)
            EMPTY: if (accept) begin
                state_nxt = ONE;
                load_out = 1'b1;
            end
            ONE: begin
`ifdef IMM_SKID_BUFFER_EN
                if (accept && !io.out_ready) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else
`endif
                if (accept) load_out = 1'b1;
                else if (io.out_ready) state_nxt = EMPTY;
            end
`ifdef IMM_SKID_BUFFER_EN
            FULL: if (io.out_ready) begin
                state_nxt = ONE;
                pop_skid = 1'b1;
            end
`endif
            default: state_nxt = EMPTY;
        endcase
    end
    always_ff @(posedge Clk or negedge Rst_n)
        if (!Rst_n) state <= EMPTY;
        else state <= state_nxt;
    always_ff @(posedge Clk or negedge Rst_n)
        if (!Rst_n) out_q <= '0;
        else if (load_out) out_q <= in_e;
`ifdef IMM_SKID_BUFFER_EN
        else if (pop_skid) out_q <= skid_q;
`endif
    assign io.out_valid = state != EMPTY;
    assign io.out_imm = out_q.imm;
    assign io.out_target = out_q.target;
    assign io.out_ext_mode = out_q.mode;
    assign io.out_instr = out_q.instr;
endmodule

// File: tb/tb_imm_extend_stage.sv
// tb_imm_extend_stage: directed vectors plus back-pressure, flush and async-reset sequences.
module tb_imm_extend_stage;
    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    logic flush = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    imm_extend_stage_if a ();
    imm_extend_stage_if b ();
    imm_extend_stage u0 (.Clk(Clk), .Rst_n(Rst_n), .flush(flush), .io(a.slave));
    imm_extend_stage #(.ZEXT_LOGIC(1'b0)) u1 (.Clk(Clk), .Rst_n(Rst_n), .flush(flush), .io(b.slave));
    assign b.in_valid = a.in_valid;
    assign b.in_instr = a.in_instr;
    assign b.in_pc4 = a.in_pc4;
    assign b.out_ready = a.out_ready;
    always #5 Clk = ~Clk;
    typedef struct {
        logic [31:0] instr, pc4, imm, tgt, imm1;
        logic [1:0]  mode, mode1;
    } vec_t;
    vec_t v[7];
    localparam logic [31:0] A = 32'h2108FFFC, B = 32'h3C081234, C = 32'h21080001;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic edge1();
        @(posedge Clk);
        #1;
    endtask
    task automatic drive(input logic vld, input logic [31:0] instr, input logic [31:0] pc4);
        a.in_valid = vld;
        a.in_instr = instr;
        a.in_pc4 = pc4;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    initial begin
        v[0] = '{32'h35088001, 32'h00000010, 32'h00008001, 32'hFFFE0014, 32'hFFFF8001, 2'b01, 2'b00};
        v[1] = '{32'h2108FFFC, 32'h00000100, 32'hFFFFFFFC, 32'h000000F0, 32'hFFFFFFFC, 2'b00, 2'b00};
        v[2] = '{32'h3C081234, 32'h00000000, 32'h12340000, 32'h000048D0, 32'h12340000, 2'b10, 2'b10};
        v[3] = '{32'h21080001, 32'hFFFFFFFC, 32'h00000001, 32'h00000000, 32'h00000001, 2'b00, 2'b00};
        v[4] = '{32'h3908FFFF, 32'h00000020, 32'h0000FFFF, 32'h0000001C, 32'hFFFFFFFF, 2'b01, 2'b00};
        v[5] = '{32'h31088000, 32'h00000000, 32'h00008000, 32'hFFFE0000, 32'hFFFF8000, 2'b01, 2'b00};
        v[6] = '{32'h1109FFFF, 32'h00001000, 32'hFFFFFFFF, 32'h00000FFC, 32'hFFFFFFFF, 2'b00, 2'b00};
        drive(1'b0, 32'h0, 32'h0);
        a.out_ready = 1'b1;
        #12;
        chk("rst_valid", {31'b0, a.out_valid}, 32'h0);
        chk("rst_imm", a.out_imm, 32'h0);
        chk("rst_target", a.out_target, 32'h0);
        chk("rst_mode", {30'b0, a.out_ext_mode}, 32'h0);
        chk("rst_instr", a.out_instr, 32'h0);
        Rst_n = 1'b1;
        edge1();
        chk("rst_in_ready", {31'b0, a.in_ready}, 32'h1);
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, v[i].instr, v[i].pc4);
            edge1();
            drive(1'b0, 32'h0, 32'h0);
            chk($sformatf("v%0d_valid", i), {31'b0, a.out_valid}, 32'h1);
            chk($sformatf("v%0d_imm", i), a.out_imm, v[i].imm);
            chk($sformatf("v%0d_target", i), a.out_target, v[i].tgt);
            chk($sformatf("v%0d_mode", i), {30'b0, a.out_ext_mode}, {30'b0, v[i].mode});
            chk($sformatf("v%0d_instr", i), a.out_instr, v[i].instr);
            chk($sformatf("v%0d_imm_sext", i), b.out_imm, v[i].imm1);
            chk($sformatf("v%0d_mode_sext", i), {30'b0, b.out_ext_mode}, {30'b0, v[i].mode1});
        end
        edge1();
        chk("drain_valid", {31'b0, a.out_valid}, 32'h0);
        a.out_ready = 1'b0;
        drive(1'b1, A, 32'h100);
        edge1();
        chk("bp_a_instr", a.out_instr, A);
        drive(1'b1, B, 32'h0);
`ifdef IMM_SKID_BUFFER_EN
        edge1();
        drive(1'b0, 32'h0, 32'h0);
        chk("bp_skid_in_ready", {31'b0, a.in_ready}, 32'h0);
        chk("bp_skid_hold_a", a.out_instr, A);
        repeat (2) begin
            edge1();
            chk("bp_skid_hold_imm", a.out_imm, 32'hFFFFFFFC);
            chk("bp_skid_hold_ready", {31'b0, a.in_ready}, 32'h0);
        end
        a.out_ready = 1'b1;
        edge1();
        chk("bp_skid_b_instr", a.out_instr, B);
        chk("bp_skid_b_imm", a.out_imm, 32'h12340000);
        chk("bp_skid_b_valid", {31'b0, a.out_valid}, 32'h1);
        chk("bp_skid_in_ready_back", {31'b0, a.in_ready}, 32'h1);
`else
        #1;
        chk("bp_in_ready_low", {31'b0, a.in_ready}, 32'h0);
        repeat (3) begin
            edge1();
            chk("bp_hold_a", a.out_instr, A);
            chk("bp_hold_target", a.out_target, 32'h000000F0);
            chk("bp_hold_ready", {31'b0, a.in_ready}, 32'h0);
        end
        a.out_ready = 1'b1;
        #1;
        chk("bp_in_ready_comb", {31'b0, a.in_ready}, 32'h1);
        edge1();
        drive(1'b0, 32'h0, 32'h0);
        chk("bp_b_instr", a.out_instr, B);
        chk("bp_b_imm", a.out_imm, 32'h12340000);
`endif
        edge1();
        chk("bp_drained", {31'b0, a.out_valid}, 32'h0);
        a.out_ready = 1'b0;
        drive(1'b1, A, 32'h100);
        edge1();
`ifdef IMM_SKID_BUFFER_EN
        drive(1'b1, B, 32'h0);
        edge1();
        chk("fl_full_ready", {31'b0, a.in_ready}, 32'h0);
`else
        a.out_ready = 1'b1;
`endif
        drive(1'b1, C, 32'h0);
        flush = 1'b1;
        edge1();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("fl_valid", {31'b0, a.out_valid}, 32'h0);
        chk("fl_in_ready", {31'b0, a.in_ready}, 32'h1);
        a.out_ready = 1'b1;
        repeat (2) begin
            edge1();
            chk("fl_no_reappear", {31'b0, a.out_valid}, 32'h0);
        end
        a.out_ready = 1'b0;
        drive(1'b1, A, 32'h100);
        edge1();
        drive(1'b1, B, 32'h0);
        edge1();
        drive(1'b0, 32'h0, 32'h0);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("ar_valid", {31'b0, a.out_valid}, 32'h0);
        chk("ar_imm", a.out_imm, 32'h0);
        chk("ar_target", a.out_target, 32'h0);
        chk("ar_instr", a.out_instr, 32'h0);
        chk("ar_mode", {30'b0, a.out_ext_mode}, 32'h0);
        #1;
        Rst_n = 1'b1;
        a.out_ready = 1'b1;
        edge1();
        chk("ar_empty", {31'b0, a.out_valid}, 32'h0);
        drive(1'b1, B, 32'h0);
        edge1();
        drive(1'b0, 32'h0, 32'h0);
        chk("ar_pass_valid", {31'b0, a.out_valid}, 32'h1);
        chk("ar_pass_imm", a.out_imm, 32'h12340000);
        chk("ar_pass_mode", {30'b0, a.out_ext_mode}, 32'h2);
        edge1();
        chk("ar_pass_drain", {31'b0, a.out_valid}, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
